// File: rtl/dphy_pkg.sv
// Shared definitions for the D-PHY HS lane sequencer: burst state encoding,
// the leader sync byte and default HS timing in byte clocks.
package dphy_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PREP  = 3'd1,
    ZERO  = 3'd2,
    SYNC  = 3'd3,
    DATA  = 3'd4,
    TRAIL = 3'd5,
    EXIT  = 3'd6
  } dphy_state_t;

  localparam logic [7:0]  DPHY_SYNC_BYTE      = 8'hB8;
  localparam int unsigned DPHY_HS_PREP_DEF    = 2;
  localparam int unsigned DPHY_HS_ZERO_DEF    = 6;
  localparam int unsigned DPHY_HS_TRAIL_DEF   = 4;
  localparam int unsigned DPHY_HS_EXIT_DEF    = 3;

  // Trail drives the complement of the last transmitted bit (MSB, sent last).
  function automatic logic [7:0] dphy_trail_byte(input logic last_bit);
    return last_bit ? 8'h00 : 8'hFF;
  endfunction

endpackage

// File: rtl/dphy_hs_lane_sequencer.sv
// D-PHY HS burst sequencer, byte-clock side of the lane serializer.
// Wraps a packet byte stream as PREP / ZERO / SYNC / payload / TRAIL / EXIT.
// Optional: define DPHY_BURST_STATS_EN to add saturating burst and underrun
// counters (burst_count, underrun_count).
//
// Handshake note: s_ready is raised in the SYNC cycle as well as in DATA, so
// the first payload byte lands on tx_byte right after the sync byte. Once the
// s_last byte has been taken, s_ready drops for the cycle that byte is on the
// wire, and the trail follows it directly.
module dphy_hs_lane_sequencer
  import dphy_pkg::*;
#(
  parameter int unsigned HS_PREP_CYCLES  = DPHY_HS_PREP_DEF,
  parameter int unsigned HS_ZERO_CYCLES  = DPHY_HS_ZERO_DEF,
  parameter int unsigned HS_TRAIL_CYCLES = DPHY_HS_TRAIL_DEF,
  parameter int unsigned HS_EXIT_CYCLES  = DPHY_HS_EXIT_DEF,
  parameter logic [7:0]  SYNC_BYTE       = DPHY_SYNC_BYTE
) (
  input  logic        tx_clock_logic,
  input  logic        rst,
  input  logic        enable,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_tristate,
  output logic        hs_prepare,
  output logic        hs_active,
  output logic        busy,
  output logic        underrun_err
`ifdef DPHY_BURST_STATS_EN
  ,
  output logic [15:0] burst_count,
  output logic [15:0] underrun_count
`endif
);

  localparam logic [7:0] LD_PREP  = 8'(HS_PREP_CYCLES - 1);
  localparam logic [7:0] LD_ZERO  = 8'(HS_ZERO_CYCLES - 1);
  localparam logic [7:0] LD_TRAIL = 8'(HS_TRAIL_CYCLES - 1);
  localparam logic [7:0] LD_EXIT  = 8'(HS_EXIT_CYCLES - 1);

  dphy_state_t r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic [7:0]  r_tx_byte, w_tx_byte_nxt;
  logic        r_tristate, w_tristate_nxt;
  logic        r_last_bit, w_last_bit_nxt;
  logic        r_eop, w_eop_nxt;
  logic        r_underrun, w_underrun;
  logic        w_cnt_zero;

  assign w_cnt_zero = (r_cnt == 8'd0);

  // Next state plus the registered lane outputs for the state being entered.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = w_cnt_zero ? 8'd0 : r_cnt - 8'd1;
    w_tx_byte_nxt  = r_tx_byte;
    w_tristate_nxt = r_tristate;
    w_last_bit_nxt = r_last_bit;
    w_eop_nxt      = r_eop;
    w_underrun     = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && s_valid) begin
          w_state_nxt    = PREP;
          w_cnt_nxt      = LD_PREP;
          w_tristate_nxt = 1'b1;
          w_tx_byte_nxt  = 8'h00;
        end
      end
      PREP: begin
        if (w_cnt_zero) begin
          w_state_nxt    = ZERO;
          w_cnt_nxt      = LD_ZERO;
          w_tristate_nxt = 1'b0;
          w_tx_byte_nxt  = 8'h00;
        end
      end
      ZERO: begin
        if (w_cnt_zero) begin
          w_state_nxt    = SYNC;
          w_tx_byte_nxt  = SYNC_BYTE;
          w_last_bit_nxt = SYNC_BYTE[7];
          w_eop_nxt      = 1'b0;
        end
      end
      SYNC, DATA: begin
        if (!r_eop && s_valid) begin
          w_state_nxt    = DATA;
          w_tx_byte_nxt  = s_data;
          w_last_bit_nxt = s_data[7];
          w_eop_nxt      = s_last;
        end else begin
          // Either the final byte is on the wire or the source starved us.
          w_underrun     = !r_eop;
          w_state_nxt    = TRAIL;
          w_cnt_nxt      = LD_TRAIL;
          w_tx_byte_nxt  = dphy_trail_byte(r_last_bit);
        end
      end
      TRAIL: begin
        if (w_cnt_zero) begin
          w_state_nxt    = EXIT;
          w_cnt_nxt      = LD_EXIT;
          w_tristate_nxt = 1'b1;
          w_tx_byte_nxt  = 8'h00;
        end
      end
      EXIT: begin
        if (w_cnt_zero) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt    = IDLE;
        w_tristate_nxt = 1'b1;
        w_tx_byte_nxt  = 8'h00;
      end
    endcase
  end

  // State, timing counter and lane output registers; reset tristates at once.
  always_ff @(posedge tx_clock_logic or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= 8'd0;
      r_tx_byte  <= 8'h00;
      r_tristate <= 1'b1;
      r_last_bit <= 1'b0;
      r_eop      <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tx_byte  <= w_tx_byte_nxt;
      r_tristate <= w_tristate_nxt;
      r_last_bit <= w_last_bit_nxt;
      r_eop      <= w_eop_nxt;
      r_underrun <= w_underrun;
    end
  end

  assign s_ready      = ((r_state == SYNC) || (r_state == DATA)) && !r_eop;
  assign tx_byte      = r_tx_byte;
  assign tx_tristate  = r_tristate;
  assign hs_prepare   = (r_state == PREP);
  assign hs_active    = (r_state == ZERO) || (r_state == SYNC) ||
                        (r_state == DATA) || (r_state == TRAIL);
  assign busy         = (r_state != IDLE);
  assign underrun_err = r_underrun;

`ifdef DPHY_BURST_STATS_EN
  logic [15:0] r_burst_cnt, r_underrun_cnt;
  logic        w_sync_entry;

  assign w_sync_entry = (r_state == ZERO) && w_cnt_zero;

  // Saturating burst / underrun statistics.
  always_ff @(posedge tx_clock_logic or posedge rst) begin
    if (rst) begin
      r_burst_cnt    <= 16'd0;
      r_underrun_cnt <= 16'd0;
    end else begin
      if (w_sync_entry && (r_burst_cnt != 16'hFFFF))
        r_burst_cnt <= r_burst_cnt + 16'd1;
      if (r_underrun && (r_underrun_cnt != 16'hFFFF))
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  assign burst_count    = r_burst_cnt;
  assign underrun_count = r_underrun_cnt;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/dphy_hs_lane_sequencer.md
Name: dphy_hs_lane_sequencer

Overview:
- Byte-clock stage directly upstream of the lane 8:1 output serializer in the MIPI DSI TX path.
- Takes a packet byte stream from the DSI packet layer and wraps it in a D-PHY high-speed burst: HS-prepare, HS-zero, sync byte 0xB8, payload, HS-trail, HS-exit.
- Drives the serializer's parallel byte input and its tristate control, which is shared across all four slots.
- Tells the LP-state controller when HS-prepare is active and when the HS driver is active.

Parameters:
- HS_PREP_CYCLES, 2, byte clocks in PREP (HS driver tristated, LP-00 requested); range 1..255.
- HS_ZERO_CYCLES, 6, byte clocks of 0x00 driven before sync; range 1..255.
- HS_TRAIL_CYCLES, 4, byte clocks of trail pattern after the last byte; range 1..255.
- HS_EXIT_CYCLES, 3, byte clocks tristated after trail before the next burst may start; range 1..255.
- SYNC_BYTE, 8'hB8, leader sequence byte.

Ports:
- tx_clock_logic  in  1  byte clock, same clock as the serializer CLKDIV.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  allows a new burst to start from IDLE.
- s_data  in  8  payload byte; bit 0 is transmitted first.
- s_valid  in  1  payload byte valid.
- s_last  in  1  marks the final byte of the burst.
- s_ready  out  1  sequencer accepts the byte this cycle.
- tx_byte  out  8  to serializer tx_in.
- tx_tristate  out  1  to serializer tx_en (T inputs); 1 = HS driver off.
- hs_prepare  out  1  LP controller drives LP-00 while high.
- hs_active  out  1  HS driver enabled (ZERO/SYNC/DATA/TRAIL).
- busy  out  1  state != IDLE.
- underrun_err  out  1  one-cycle pulse on payload starvation.

Behaviour:
- Interface: one clock, tx_clock_logic; reset rst is asynchronous, active-high.
- Reset values: state=IDLE, tx_byte=8'h00, tx_tristate=1, s_ready=0, hs_prepare=0, hs_active=0, busy=0, underrun_err=0.
- tx_byte and tx_tristate are registered and take the value for the state entered, in that same cycle. One down-counter, loaded with N-1 on state entry; a state exits when the counter is 0.
- IDLE: tristate=1. On enable & s_valid, go to PREP. No byte is consumed.
- PREP (HS_PREP_CYCLES): tristate=1, hs_prepare=1, then go to ZERO.
- ZERO (HS_ZERO_CYCLES): tristate=0, tx_byte=0x00, then go to SYNC.
- SYNC (1 cycle): tx_byte=SYNC_BYTE, then go to DATA.
- DATA: s_ready=1 combinationally while in DATA.
  - An accepted byte appears on tx_byte the next cycle. Bit 7 of each accepted byte is saved as last_bit.
  - Accepting with s_last=1 sends the next state to TRAIL.
  - s_valid=0 in DATA is an underrun: pulse underrun_err, go to TRAIL with the current last_bit.
- SYNC→DATA gives one cycle of s_ready with no bubble. The first payload byte follows SYNC contiguously only if s_valid is already high; otherwise the underrun rule applies.
- TRAIL (HS_TRAIL_CYCLES): tx_byte = last_bit ? 8'h00 : 8'hFF, i.e. the inverse of the final bit. Then go to EXIT.
- EXIT (HS_EXIT_CYCLES): tristate=1, tx_byte=0x00, then go to IDLE.
- enable is sampled only in IDLE; deasserting it mid-burst does not abort the burst.
- A reset mid-burst immediately tristates the lane and returns to IDLE. The partial burst is discarded, not retried.
- s_data, s_last and s_valid are ignored outside DATA. s_last on the first data byte gives a 1-byte burst.

Optional Feature:
- DPHY_BURST_STATS_EN defined: adds outputs burst_count[15:0] and underrun_count[15:0].
  - burst_count increments on SYNC entry; underrun_count increments with underrun_err.
  - Both saturate at 0xFFFF and clear on rst.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package dphy_pkg: state enum (IDLE, PREP, ZERO, SYNC, DATA, TRAIL, EXIT), DPHY_SYNC_BYTE=8'hB8, default timing constants.
- No sub-module: the timing counter and FSM stay inline. The serializer is instantiated by the lane top, not here.

Test Plan:
- Reset defaults: hold rst, then release → tx_tristate=1, busy=0, s_ready=0 until enable & s_valid.
- Nominal 3-byte burst, defaults, bytes 0x11, 0x22, 0x83(last):
  - Sequence is 2 PREP, then 6×0x00, 0xB8, 0x11, 0x22, 0x83.
  - Then 4×0x00 trail (bit7=1), then 3 tristated cycles, then IDLE.
- Trail polarity: last byte 0x7F → 4×0xFF trail.
- Underrun: drop s_valid after 0x11 → underrun_err high for exactly 1 cycle, trail 4×0xFF, then normal EXIT.
- Async reset mid-DATA: assert rst between clock edges → tx_tristate=1 immediately, state IDLE, no trail emitted.
- Back-to-back bursts: s_valid held high across both → second PREP starts no earlier than the cycle after the 3rd EXIT cycle. With DPHY_BURST_STATS_EN defined, burst_count=2.
